processor1_pipeline: RTL and testbench



---
 rtl/processor1_pipeline.sv | 152 +++++++++++++++
 tb/tb_processor1_pipeline.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/processor1_pipeline.sv
// processor1_pipeline: 5-stage MIPS-subset core with unified word memory and full EX forwarding.
// Define PROC1_MUL_EN to build the MUL instruction; without it opcode 000101 is a NOP.
module processor1_pipeline (
   input  logic clk1,
   input  logic rst_n,
   output logic halted
);
   typedef enum logic [2:0] {T_NOP, T_RR, T_RM, T_LW, T_SW, T_BR, T_HLT} itype_t;

   localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010,
                          OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101,
                          OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010,
                          OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                          OP_BEQZ = 6'b001110, OP_HLT  = 6'b111111;

   logic [31:0] Reg [0:31];
   logic [31:0] Mem [0:1023];
   logic [9:0]  PC;
   logic        branch_taken;
   logic        fetch_stop;

   logic        if_id_v;
   logic [31:0] if_id_ir;
   logic [9:0]  if_id_npc;

   itype_t      id_ex_t;
   logic [5:0]  id_ex_op;
   logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst;
   logic        id_ex_wr;
   logic [31:0] id_ex_a, id_ex_b, id_ex_imm;
   logic [9:0]  id_ex_npc;

   itype_t      ex_mem_t;
   logic        ex_mem_wr;
   logic [4:0]  ex_mem_dst;
   logic [31:0] ex_mem_alu, ex_mem_b;

   itype_t      mem_wb_t;
   logic        mem_wb_wr;
   logic [4:0]  mem_wb_dst;
   logic [31:0] mem_wb_alu, mem_wb_lmd;

   logic [31:0] wb_val;
   logic        wb_en;
   assign wb_val = (mem_wb_t == T_LW) ? mem_wb_lmd : mem_wb_alu;
   assign wb_en  = mem_wb_wr && !halted;

   // ID: decode and register read (WB write is visible in the same cycle)
   logic [4:0]  id_rs, id_rt;
   itype_t      id_t;
   logic        id_wr;
   logic [4:0]  id_dst;
   logic [31:0] id_a, id_b, id_imm;
   assign id_rs  = if_id_ir[25:21];
   assign id_rt  = if_id_ir[20:16];
   assign id_imm = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
   assign id_a   = (id_rs == 5'd0) ? 32'd0 : (wb_en && mem_wb_dst == id_rs) ? wb_val : Reg[id_rs];
   assign id_b   = (id_rt == 5'd0) ? 32'd0 : (wb_en && mem_wb_dst == id_rt) ? wb_val : Reg[id_rt];

   always_comb begin
      id_t   = T_NOP;
      id_wr  = 1'b0;
      id_dst = if_id_ir[15:11];
      if (if_id_v) begin
         case (if_id_ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin id_t = T_RR; id_wr = 1'b1; end
`ifdef PROC1_MUL_EN
            OP_MUL: begin id_t = T_RR; id_wr = 1'b1; end
`endif
            OP_ADDI, OP_SUBI, OP_SLTI: begin id_t = T_RM; id_wr = 1'b1; id_dst = id_rt; end
            OP_LW:    begin id_t = T_LW; id_wr = 1'b1; id_dst = id_rt; end
            OP_SW:    id_t = T_SW;
            OP_BNEQZ, OP_BEQZ: id_t = T_BR;
            OP_HLT:   id_t = T_HLT;
            default:  id_t = T_NOP;
         endcase
      end
      if (id_dst == 5'd0) id_wr = 1'b0;
   end

   // EX operands: EX/MEM ALU result wins over MEM/WB, which wins over the ID-stage read
   logic [31:0] fwd_a, fwd_b, alu;
   logic        exm_fwd;
   assign exm_fwd = ex_mem_wr && (ex_mem_t != T_LW);
   assign fwd_a = (exm_fwd && ex_mem_dst == id_ex_rs) ? ex_mem_alu :
                  (mem_wb_wr && mem_wb_dst == id_ex_rs) ? wb_val : id_ex_a;
   assign fwd_b = (exm_fwd && ex_mem_dst == id_ex_rt) ? ex_mem_alu :
                  (mem_wb_wr && mem_wb_dst == id_ex_rt) ? wb_val : id_ex_b;

   always_comb begin
      alu = 32'd0;
      case (id_ex_op)
         OP_ADD:  alu = fwd_a + fwd_b;
         OP_SUB:  alu = fwd_a - fwd_b;
         OP_AND:  alu = fwd_a & fwd_b;
         OP_OR:   alu = fwd_a | fwd_b;
         OP_SLT:  alu = ($signed(fwd_a) < $signed(fwd_b)) ? 32'd1 : 32'd0;
`ifdef PROC1_MUL_EN
         OP_MUL:  alu = fwd_a * fwd_b;
`endif
         OP_ADDI, OP_LW, OP_SW: alu = fwd_a + id_ex_imm;
         OP_SUBI: alu = fwd_a - id_ex_imm;
         OP_SLTI: alu = ($signed(fwd_a) < $signed(id_ex_imm)) ? 32'd1 : 32'd0;
         default: alu = 32'd0;
      endcase
   end

   assign branch_taken = (id_ex_t == T_BR) &&
                         ((id_ex_op == OP_BEQZ) ? (fwd_a == 32'd0) : (fwd_a != 32'd0));

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         PC <= '0; fetch_stop <= 1'b0; halted <= 1'b0;
         if_id_v <= 1'b0; if_id_ir <= '0; if_id_npc <= '0;
         id_ex_t <= T_NOP; id_ex_op <= '0; id_ex_rs <= '0; id_ex_rt <= '0; id_ex_dst <= '0;
         id_ex_wr <= 1'b0; id_ex_a <= '0; id_ex_b <= '0; id_ex_imm <= '0; id_ex_npc <= '0;
         ex_mem_t <= T_NOP; ex_mem_wr <= 1'b0; ex_mem_dst <= '0; ex_mem_alu <= '0; ex_mem_b <= '0;
         mem_wb_t <= T_NOP; mem_wb_wr <= 1'b0; mem_wb_dst <= '0; mem_wb_alu <= '0; mem_wb_lmd <= '0;
      end else begin
         ex_mem_t <= id_ex_t; ex_mem_wr <= id_ex_wr; ex_mem_dst <= id_ex_dst;
         ex_mem_alu <= alu; ex_mem_b <= fwd_b;
         mem_wb_t <= ex_mem_t; mem_wb_wr <= ex_mem_wr; mem_wb_dst <= ex_mem_dst;
         mem_wb_alu <= ex_mem_alu; mem_wb_lmd <= Mem[ex_mem_alu[9:0]];
         if (mem_wb_t == T_HLT) halted <= 1'b1;
         if (branch_taken) begin
            PC <= id_ex_npc + id_ex_imm[9:0];
            if_id_v <= 1'b0;
            id_ex_t <= T_NOP; id_ex_op <= '0; id_ex_wr <= 1'b0;
         end else begin
            id_ex_t <= id_t; id_ex_op <= if_id_ir[31:26]; id_ex_rs <= id_rs; id_ex_rt <= id_rt;
            id_ex_dst <= id_dst; id_ex_wr <= id_wr; id_ex_a <= id_a; id_ex_b <= id_b;
            id_ex_imm <= id_imm; id_ex_npc <= if_id_npc;
            // HLT in ID drops the instruction fetched behind it and freezes PC for good
            if (id_t == T_HLT) begin
               fetch_stop <= 1'b1;
               if_id_v <= 1'b0;
            end else if (!fetch_stop) begin
               if_id_v <= 1'b1; if_id_ir <= Mem[PC]; if_id_npc <= PC + 10'd1;
               PC <= PC + 10'd1;
            end else begin
               if_id_v <= 1'b0;
            end
         end
      end
   end

   // Architectural writes: store at end of MEM, register write at end of WB
   always_ff @(posedge clk1) begin
      if (ex_mem_t == T_SW && !halted) Mem[ex_mem_alu[9:0]] <= ex_mem_b;
      if (wb_en) Reg[mem_wb_dst] <= wb_val;
   end
endmodule

// File: tb/tb_processor1_pipeline.sv
// tb_processor1_pipeline: runs small programs on processor1_pipeline and checks registers/memory.
// Build with PROC1_MUL_EN defined to expect MUL results instead of NOP behaviour.
module tb_processor1_pipeline;
   logic clk1, rst_n, halted;
   int   n_total = 0, n_bad = 0;
   int   br_cnt = 0, br_base = 0, edges = 0;
   logic [31:0] exp_q[$];
   int          loc_q[$];
   logic [31:0] prog_q[$];
   logic [9:0]  pc_snap;

   localparam logic [31:0] NOP = 32'h1c000000;
   localparam logic [31:0] HLT = 32'hfc000000;

   processor1_pipeline dut (.clk1(clk1), .rst_n(rst_n), .halted(halted));

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   always @(negedge clk1) if (dut.branch_taken) br_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
      enc_r = {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
      enc_i = {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic expect_reg(input int r, input logic [31:0] v);
      loc_q.push_back(r); exp_q.push_back(v);
   endtask

   task automatic expect_mem(input int a, input logic [31:0] v);
      loc_q.push_back(1000 + a); exp_q.push_back(v);
   endtask

   task automatic begin_test();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 1024; i++) dut.Mem[i] = NOP;
      for (int k = 0; k < 32; k++) dut.Reg[k] = k;
      prog_q.delete();
   endtask

   task automatic release_reset(input string name);
      for (int i = 0; i < prog_q.size(); i++) dut.Mem[i] = prog_q[i];
      check({name, "_rst_pc"}, 32'(dut.PC), 32'd0);
      check({name, "_rst_halted"}, 32'(halted), 32'd0);
      check({name, "_rst_br"}, 32'(dut.branch_taken), 32'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      br_base = br_cnt;
   endtask

   task automatic run_to_halt(input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(posedge clk1);
         n++;
         #1;
         if (halted) break;
      end
      if (!halted) check("halt_timeout", 32'(halted), 32'd1);
   endtask

   task automatic drain(input string name);
      logic [31:0] e, got;
      int l;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         l = loc_q.pop_front();
         if (l >= 1000) got = dut.Mem[l - 1000];
         else got = dut.Reg[l];
         check($sformatf("%s_%s%0d", name, (l >= 1000) ? "mem" : "r", (l >= 1000) ? l - 1000 : l), got, e);
      end
   endtask

   initial begin
      rst_n = 1'b0;

      // basic program with spacing NOPs (OR R15,R7,R7 writes R15 = 7)
      begin_test();
      prog_q = '{32'h2801000a, 32'h28020014, 32'h2803001e, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, HLT};
      expect_reg(0, 0); expect_reg(1, 10); expect_reg(2, 20); expect_reg(3, 30);
      expect_reg(4, 30); expect_reg(5, 60); expect_reg(15, 7);
      release_reset("basic");
      run_to_halt(60, edges);
      check("basic_halt_edges", edges, 13);
      drain("basic");

      // back-to-back dependencies through EX/MEM and MEM/WB
      begin_test();
      prog_q = '{enc_i(6'b001010, 1, 0, 5), enc_r(6'b000000, 2, 1, 1), enc_r(6'b000001, 3, 2, 1), HLT};
      expect_reg(1, 5); expect_reg(2, 10); expect_reg(3, 5);
      release_reset("fwd");
      run_to_halt(60, edges);
      check("fwd_halt_edges", edges, 8);
      drain("fwd");

      // load/store with load-use distance two and SW data forwarded
      begin_test();
      dut.Mem[120] = 32'd85;
      prog_q = '{enc_i(6'b001010, 1, 0, 120), enc_i(6'b001000, 2, 1, 0), NOP,
                 enc_i(6'b001010, 3, 2, 45), enc_i(6'b001001, 3, 1, 1), HLT};
      expect_reg(2, 85); expect_reg(3, 130); expect_mem(121, 130); expect_mem(120, 85);
      release_reset("ldst");
      run_to_halt(60, edges);
      check("ldst_halt_edges", edges, 10);
      drain("ldst");

      // branches: BEQZ not taken, BNEQZ taken over two writes of R9
      begin_test();
      prog_q = '{enc_i(6'b001010, 1, 0, 1), enc_i(6'b001110, 0, 1, 1), enc_i(6'b001101, 0, 1, 2),
                 enc_i(6'b001010, 9, 0, 77), enc_i(6'b001010, 9, 0, 88), enc_i(6'b001010, 10, 0, 33), HLT};
      expect_reg(1, 1); expect_reg(9, 9); expect_reg(10, 33);
      release_reset("br");
      run_to_halt(60, edges);
      check("br_halt_edges", edges, 11);
      check("br_pulses", br_cnt - br_base, 1);
      drain("br");

      // signed compares, immediates, R0 write ignored, taken BEQZ on R0
      begin_test();
      prog_q = '{enc_i(6'b001010, 1, 0, -5), enc_r(6'b000100, 2, 1, 0), enc_i(6'b001100, 3, 1, -6),
                 enc_i(6'b001011, 4, 0, 3), enc_r(6'b000010, 5, 12, 10), enc_r(6'b000011, 6, 12, 10),
                 enc_r(6'b000001, 8, 0, 1), enc_i(6'b001010, 0, 0, 7), enc_i(6'b001110, 0, 0, 1),
                 enc_i(6'b001010, 13, 0, 1), enc_i(6'b001010, 14, 0, 2), enc_r(6'b000100, 15, 0, 1), HLT};
      expect_reg(1, 32'hfffffffb); expect_reg(2, 1); expect_reg(3, 0); expect_reg(4, 32'hfffffffd);
      expect_reg(5, 8); expect_reg(6, 14); expect_reg(8, 5); expect_reg(0, 0);
      expect_reg(13, 13); expect_reg(14, 2); expect_reg(15, 0);
      release_reset("alu");
      run_to_halt(80, edges);
      check("alu_br_pulses", br_cnt - br_base, 1);
      drain("alu");

      // multiply, then a dependent ADD
      begin_test();
      dut.Reg[2] = 32'd6; dut.Reg[3] = 32'd7; dut.Reg[11] = 32'hfffffffd;
      prog_q = '{enc_r(6'b000101, 4, 2, 3), enc_r(6'b000101, 5, 11, 3), enc_r(6'b000000, 6, 4, 5), HLT};
`ifdef PROC1_MUL_EN
      expect_reg(4, 42); expect_reg(5, 32'hffffffeb); expect_reg(6, 21);
`else
      expect_reg(4, 4); expect_reg(5, 5); expect_reg(6, 9);
`endif
      release_reset("mul");
      run_to_halt(60, edges);
      drain("mul");

      // HLT then a write that must never happen; halted holds; async reset clears at once
      begin_test();
      prog_q = '{HLT, enc_i(6'b001010, 6, 0, 99)};
      expect_reg(6, 6);
      release_reset("hlt");
      run_to_halt(60, edges);
      check("hlt_halt_edges", edges, 5);
      pc_snap = dut.PC;
      repeat (8) @(posedge clk1);
      #1;
      check("hlt_hold", 32'(halted), 32'd1);
      check("hlt_pc_frozen", 32'(dut.PC), 32'(pc_snap));
      drain("hlt");
      #2;
      rst_n = 1'b0;
      #1;
      check("hlt_async_halted", 32'(halted), 32'd0);
      check("hlt_async_pc", 32'(dut.PC), 32'd0);

      // reset mid-run discards in-flight work and restarts from address 0
      begin_test();
      prog_q = '{enc_i(6'b001010, 1, 0, 5), enc_r(6'b000000, 2, 1, 1), enc_r(6'b000001, 3, 2, 1), HLT};
      expect_reg(2, 10); expect_reg(3, 5);
      release_reset("mid");
      repeat (3) @(posedge clk1);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_async_pc", 32'(dut.PC), 32'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      run_to_halt(60, edges);
      check("mid_halt_edges", edges, 8);
      drain("mid");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
